// File: rtl/ganesha.sv
// 32 x 64 synchronous image ROM holding a mirror-symmetric Ganesha bitmap.
// Only the left half is stored; the right half is its bit-reverse.
module ganesha (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [4:0]  address,
    output logic [63:0] data_out
);

    logic [63:0] data_q;
    logic [63:0] data_d;
    logic [31:0] left_half;
    logic [31:0] right_half;

    always_comb begin
        left_half = 32'h0000_0000;
        case (address)
            5'd0:  left_half = 32'h0000_0000;
            5'd1:  left_half = 32'h0000_0007;
            5'd2:  left_half = 32'h0000_001F;
            5'd3:  left_half = 32'h0000_007F;
            5'd4:  left_half = 32'h0000_01FF;
            5'd5:  left_half = 32'h0000_0FFF;
            5'd6:  left_half = 32'h0FC0_3FFF;
            5'd7:  left_half = 32'h3FF0_FFFF;
            5'd8:  left_half = 32'h7FF9_FFFF;
            5'd9:  left_half = 32'hFFFF_FFFF;
            5'd10: left_half = 32'hFFFF_FF87;
            5'd11: left_half = 32'hFFFF_FF87;
            5'd12: left_half = 32'hFFFF_FFFF;
            5'd13: left_half = 32'h7FFF_FFFF;
            5'd14: left_half = 32'h3FFF_FFFF;
            5'd15: left_half = 32'h1FFF_FFF0;
            5'd16: left_half = 32'h0FFF_FF0F;
            5'd17: left_half = 32'h07FF_E00F;
            5'd18: left_half = 32'h03FF_C00F;
            5'd19: left_half = 32'h01FF_800F;
            5'd20: left_half = 32'h007F_000F;
            5'd21: left_half = 32'h0000_000F;
            5'd22: left_half = 32'h0000_000F;
            5'd23: left_half = 32'h0000_001F;
            5'd24: left_half = 32'h0000_003F;
            5'd25: left_half = 32'h0000_007E;
            5'd26: left_half = 32'h0000_00FC;
            5'd27: left_half = 32'h0000_03F8;
            5'd28: left_half = 32'h0000_0FF0;
            5'd29: left_half = 32'h0000_3FE0;
            5'd30: left_half = 32'h0000_FF00;
            5'd31: left_half = 32'h0000_0000;
            default: left_half = 32'h0000_0000;
        endcase
    end

    // Pixel 31-k of the right half mirrors pixel 32+k of the row.
    always_comb begin
        right_half = 32'h0000_0000;
        for (int k = 0; k < 32; k++) begin
            right_half[31-k] = left_half[k];
        end
    end

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = {left_half, right_half};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= 64'h0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: tb/tb_ganesha.sv
// Scoreboard bench for the ganesha image ROM: each driven cycle pushes the
// expected row, which is popped and compared one edge later.
module tb_ganesha;

  logic        clk;
  logic        rst;
  logic        en;
  logic [4:0]  address;
  logic [63:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_q[$];
  logic [63:0] model_q;

  logic [31:0] left_tbl [32] = '{
    32'h00000000, 32'h00000007, 32'h0000001F, 32'h0000007F,
    32'h000001FF, 32'h00000FFF, 32'h0FC03FFF, 32'h3FF0FFFF,
    32'h7FF9FFFF, 32'hFFFFFFFF, 32'hFFFFFF87, 32'hFFFFFF87,
    32'hFFFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h1FFFFFF0,
    32'h0FFFFF0F, 32'h07FFE00F, 32'h03FFC00F, 32'h01FF800F,
    32'h007F000F, 32'h0000000F, 32'h0000000F, 32'h0000001F,
    32'h0000003F, 32'h0000007E, 32'h000000FC, 32'h000003F8,
    32'h00000FF0, 32'h00003FE0, 32'h0000FF00, 32'h00000000
  };

  ganesha dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .address  (address),
    .data_out (data_out)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] row_of(input logic [4:0] a);
    logic [31:0] l;
    logic [63:0] r;
    l = left_tbl[a];
    r[63:32] = l;
    for (int i = 0; i < 32; i++) begin
      r[i] = l[31-i];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: apply inputs on the falling edge, push the expected row,
  // then pop and compare just after the rising edge
  task automatic step(input logic r, input logic e, input logic [4:0] a, input string tag);
    logic [63:0] exp;
    @(negedge clk);
    rst = r;
    en = e;
    address = a;
    if (r) model_q = 64'h0;
    else if (e) model_q = row_of(a);
    exp_q.push_back(model_q);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_empty_q"}, data_out, 64'hx);
    end else begin
      exp = exp_q.pop_front();
      check(tag, data_out, exp);
    end
    check({tag, "_no_x"}, {63'h0, $isunknown(data_out)}, 64'h0);
  endtask

  initial begin
    logic [5:0] drv;
    rst = 1'b1;
    en = 1'b1;
    address = 5'd9;
    model_q = 64'h0;

    // reset with en=1, address=9
    step(1'b1, 1'b1, 5'd9, "reset0");
    check("reset0_lit", data_out, 64'h0);
    step(1'b1, 1'b1, 5'd9, "reset1");
    check("reset1_lit", data_out, 64'h0);
    step(1'b0, 1'b1, 5'd9, "release");
    check("release_lit", data_out, 64'hFFFFFFFF_FFFFFFFF);

    // full scan
    for (int a = 0; a < 32; a++) begin
      step(1'b0, 1'b1, a[4:0], $sformatf("scan_a%0d", a));
      case (a)
        0:  check("scan_lit0",  data_out, 64'h0000000000000000);
        1:  check("scan_lit1",  data_out, 64'h00000007E0000000);
        9:  check("scan_lit9",  data_out, 64'hFFFFFFFFFFFFFFFF);
        10: check("scan_lit10", data_out, 64'hFFFFFF87E1FFFFFF);
        31: check("scan_lit31", data_out, 64'h0000000000000000);
        default: ;
      endcase
    end

    // hold with en low
    step(1'b0, 1'b1, 5'd10, "hold_load");
    step(1'b0, 1'b0, 5'd1,  "hold_a1");
    step(1'b0, 1'b0, 5'd5,  "hold_a5");
    step(1'b0, 1'b0, 5'd20, "hold_a20");
    check("hold_lit", data_out, 64'hFFFFFF87E1FFFFFF);
    step(1'b0, 1'b1, 5'd1,  "hold_reen");
    check("hold_reen_lit", data_out, 64'h00000007E0000000);

    // wrap: driver counter goes 31 -> 32, truncated to 5 bits
    drv = 6'd31;
    step(1'b0, 1'b1, drv[4:0], "wrap31");
    drv = drv + 6'd1;
    step(1'b0, 1'b1, drv[4:0], "wrap32");
    check("wrap_lit", data_out, 64'h0);

    // reset mid-scan at address 17, then resume
    for (int a = 14; a < 17; a++) step(1'b0, 1'b1, a[4:0], $sformatf("mid_a%0d", a));
    step(1'b1, 1'b1, 5'd17, "mid_rst");
    check("mid_rst_lit", data_out, 64'h0);
    for (int a = 17; a < 22; a++) step(1'b0, 1'b1, a[4:0], $sformatf("resume_a%0d", a));

    // random traffic
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 31)), $sformatf("rand%0d", i));
    end

    if (exp_q.size() != 0) check("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ganesha.md
Name: ganesha

Overview:
- Synchronous 32-row x 64-bit image ROM holding a mirror-symmetric "digital Ganesha" bitmap, one row per address.
- A display or scan-out driver steps `address` 0..31 with `en` high and receives one 64-pixel row per clock.
- Pure lookup block: no writes, no handshake beyond `en`.

Parameters:
- None. Depth 32 and width 64 are fixed.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  read enable; the row is loaded only when high
- address  input  5  row select, 0..31
- data_out  output  64  registered row data; bit 63 = leftmost pixel, 1 = pixel on

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
- Every rising edge of clk, in priority order:
  - rst=1: data_out <= 64'h0. Reset overrides en, including mid-scan.
  - rst=0, en=1: data_out <= ROM[address].
  - rst=0, en=0: data_out holds its previous value.
- Latency: exactly 1 cycle. An address presented before edge N appears on data_out after edge N. data_out has no combinational path from address.
- Address is 5 bits, so no out-of-range case exists. A driver writing 32 wraps naturally to row 0 by truncation.
- Row construction:
  - L = left half, data_out[63:32], taken from the table below.
  - Right half is the bit-mirror of L: data_out[31-k] = data_out[32+k] for k = 0..31.
- Left-half table (hex, rows in order):
  - 0-7: 00000000 00000007 0000001F 0000007F 000001FF 00000FFF 0FC03FFF 3FF0FFFF
  - 8-15: 7FF9FFFF FFFFFFFF FFFFFF87 FFFFFF87 FFFFFFFF 7FFFFFFF 3FFFFFFF 1FFFFFF0
  - 16-23: 0FFFFF0F 07FFE00F 03FFC00F 01FF800F 007F000F 0000000F 0000000F 0000001F
  - 24-31: 0000003F 0000007E 000000FC 000003F8 00000FF0 00003FE0 0000FF00 00000000
- ROM implementation:
  - Combinational case statement, or an initialized constant array; either is acceptable.
  - Synthesizable, with no $readmemh dependency.
  - The mirror may be generated in RTL or hard-coded, provided the full 64-bit values match.
- Simultaneous address change and en toggle at the same edge: the sampled values at that edge decide the result, per the priority rules above.
- No X may ever appear on data_out after the first reset edge.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1, address=9 -> data_out=64'h0 after each edge. Release rst -> next edge gives FFFFFFFF_FFFFFFFF.
- Full scan: en=1, address 0..31, one per cycle -> each row appears 1 cycle later.
  - addr 0 -> 0000000000000000
  - addr 1 -> 00000007E0000000
  - addr 9 -> FFFFFFFFFFFFFFFF
  - addr 10 -> FFFFFF87E1FFFFFF
  - addr 31 -> 0000000000000000
- Hold: load addr 10, then set en=0 and change address to 1, 5 and 20 -> data_out stays FFFFFF87E1FFFFFF. Re-raise en with address=1 -> 00000007E0000000 one edge later.
- Wrap: driver assigns 32 after 31 (truncates to 0) -> data_out 0000000000000000.
- Mirror check: for every address, data_out[31:0] equals the bit-reverse of data_out[63:32], and the left half matches the table.
- Reset mid-scan: assert rst while stepping at addr 17 -> next edge data_out=0. After release, stepping resumes with correct rows.
